register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   Architectural GPR file: the sink of the WB stage's register-file write bus.
//   Accepts one byte-strobed write per cycle from wb_stage via wb_to_register_file_bus.
//   Serves two combinational read ports to the ID stage.
//   $0 is hardwired to zero. Sits between WB (write) and ID (operand read).
// PARAMETERS
//   ADDRESS_WIDTH   5    register index width; entry count = 2**ADDRESS_WIDTH
//   DATA_WIDTH      32   register width; strobe width = DATA_WIDTH/8 (must be multiple of 8)
// PORTS
//   clock                    in   1             single clock; all state updates on posedge
//   reset                    in   1             asynchronous, active-high; clears all entries
//   wb_to_register_file_bus  in   struct        wb_stage_params::WBToRegisterFileData:
//                                               write_enabled(1), write_address(5), write_strobe(4), write_data(32)
//   read_address_1           in   ADDRESS_WIDTH ID rs index
//   read_data_1              out  DATA_WIDTH    value of read_address_1
//   read_address_2           in   ADDRESS_WIDTH ID rt index
//   read_data_2              out  DATA_WIDTH    value of read_address_2
//   write_count              out  32            committed-write counter (debug/perf)
// BEHAVIOUR
// - Reset (async, immediate on reset=1): all entries <= 0, write_count <= 0; read_data_* therefore 0.
//   A write presented in a cycle where reset is high is dropped.
// - Write commit at posedge clock when write_enabled=1 and write_address!=0:
//   for each lane i in 0..3 with write_strobe[i]=1, entry[addr][8i+7:8i] <= write_data[8i+7:8i];
//   lanes with strobe 0 keep their old bytes.
// - write_address=0: write discarded, entry 0 stays 0, write_count unchanged.
// - write_enabled=1 with write_strobe=4'b0000: no entry change, write_count unchanged.
// - write_count increments by 1 per committed write (enabled, addr!=0, strobe!=0); wraps 0xFFFFFFFF->0.
// - Reads: purely combinational, zero latency; read_address=0 always returns 0.
// - Both read ports may address the same entry or the write target; no arbitration, no stall.
// - No handshake: file is always ready; the WB valid gating is already folded into write_enabled.
// - Same-cycle read-of-write behaviour depends on REGFILE_WRITE_BYPASS_EN (below).
// CONFIGURATION
//   REGFILE_WRITE_BYPASS_EN defined:
//     when write_enabled=1, write_address!=0 and read_address_n==write_address, read_data_n returns
//     the merged value: write_data bytes on strobed lanes, stored bytes on unstrobed lanes
//     (write-first, same cycle).
//   REGFILE_WRITE_BYPASS_EN undefined:
//     read_data_n returns the stored (pre-write) value; the new value is visible from the cycle
//     after commit. ID must then take WB data from wb_to_id_back_pass_bus.
// TESTING
// 1. Assert reset mid-run after writing r5=0x12345678.
//    -> read r5=0 immediately (async), write_count=0.
// 2. Write r3 data=0xDEADBEEF, strobe=4'b1111; next cycle read_address_1=3.
//    -> read_data_1=0xDEADBEEF, write_count=1.
// 3. r3=0xDEADBEEF, then write r3 data=0x000000AA, strobe=4'b0001.
//    -> r3=0xDEADBEAA; strobe=4'b1100 data=0x55660000 -> r3=0x5566BEAA.
// 4. Write r0 data=0xFFFFFFFF, strobe=4'b1111.
//    -> read r0=0, write_count unchanged; write r7 with strobe=0 -> r7 unchanged, count unchanged.
// 5. r9=0x11111111; same cycle write r9 data=0x22222222 strobe=4'b0011, read_address_2=9.
//    -> with _EN: 0x11112222; without: 0x11111111, then 0x11112222 next cycle.
// 6. Both ports read r4 while r4 is written with reset asserted the same cycle.
//    -> write dropped, r4=0 on both ports.

Source files
------------

// File: rtl/register_file.sv
// Architectural GPR file: WB-stage byte-strobed write sink, two async ID read ports.
// Optional REGFILE_WRITE_BYPASS_EN: same-cycle write-first forwarding to read ports.

package wb_stage_params;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int WB_STRB_W = WB_DATA_W / 8;

  typedef struct packed {
    logic                 write_enabled;
    logic [WB_ADDR_W-1:0] write_address;
    logic [WB_STRB_W-1:0] write_strobe;
    logic [WB_DATA_W-1:0] write_data;
  } WBToRegisterFileData;
endpackage

module register_file
  import wb_stage_params::*;
#(
  parameter int ADDRESS_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH    = WB_DATA_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  WBToRegisterFileData      wb_to_register_file_bus,
  input  logic [ADDRESS_WIDTH-1:0] read_address_1,
  output logic [DATA_WIDTH-1:0]    read_data_1,
  input  logic [ADDRESS_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0]    read_data_2,
  output logic [31:0]              write_count
);

  localparam int ENTRIES = 2 ** ADDRESS_WIDTH;
  localparam int LANES   = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]    regs_q [ENTRIES];
  logic [DATA_WIDTH-1:0]    regs_d [ENTRIES];
  logic [31:0]              count_q;
  logic [31:0]              count_d;

  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [LANES-1:0]         wr_strb;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     wr_hit;
  logic                     commit;
  logic [DATA_WIDTH-1:0]    merged;

  assign wr_en   = wb_to_register_file_bus.write_enabled;
  assign wr_addr = ADDRESS_WIDTH'(wb_to_register_file_bus.write_address);
  assign wr_strb = LANES'(wb_to_register_file_bus.write_strobe);
  assign wr_data = DATA_WIDTH'(wb_to_register_file_bus.write_data);

  // A write targeting $0 is a no-op; one with no strobed lane changes nothing
  assign wr_hit = wr_en && (wr_addr != '0);
  assign commit = wr_hit && (wr_strb != '0);

  // Byte-lane merge of incoming data over the stored target entry
  always_comb begin
    merged = regs_q[wr_addr];
    for (int i = 0; i < LANES; i++) begin
      if (wr_strb[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  // Next-state for the entry array and the committed-write counter
  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (commit) begin
      regs_d[wr_addr] = merged;
      count_d         = count_q + 32'd1;
    end
  end

  // State update; reset clears everything and swallows a concurrent write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < ENTRIES; e++) regs_q[e] <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  // Combinational read ports; $0 always reads zero
  always_comb begin
    read_data_1 = '0;
    read_data_2 = '0;
    if (read_address_1 != '0) read_data_1 = regs_q[read_address_1];
    if (read_address_2 != '0) read_data_2 = regs_q[read_address_2];
`ifdef REGFILE_WRITE_BYPASS_EN
    // Write-first forwarding; suppressed while reset drops the write
    if (!reset && wr_hit && read_address_1 == wr_addr) read_data_1 = merged;
    if (!reset && wr_hit && read_address_2 == wr_addr) read_data_2 = merged;
`endif
  end

  assign write_count = count_q;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expectations,
// a negedge monitor pops and compares them against the read ports and counter.

module tb_register_file;
  import wb_stage_params::*;

  logic                clock;
  logic                reset;
  WBToRegisterFileData bus;
  logic [4:0]          ra1;
  logic [4:0]          ra2;
  logic [31:0]         rd1;
  logic [31:0]         rd2;
  logic [31:0]         wcnt;

  int total;
  int bad;

  string       sb_name [$];
  int          sb_sel  [$];
  logic [31:0] sb_exp  [$];

  register_file dut (
    .clock                   (clock),
    .reset                   (reset),
    .wb_to_register_file_bus (bus),
    .read_address_1          (ra1),
    .read_data_1             (rd1),
    .read_address_2          (ra2),
    .read_data_2             (rd2),
    .write_count             (wcnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic r, input logic we,
                      input logic [4:0] a, input logic [3:0] s,
                      input logic [31:0] d,
                      input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clock);
    #1;
    reset                 = r;
    bus.write_enabled     = we;
    bus.write_address     = a;
    bus.write_strobe      = s;
    bus.write_data        = d;
    ra1                   = r1;
    ra2                   = r2;
  endtask

  task automatic expect_v(input string n, input int sel,
                          input logic [31:0] v);
    sb_name.push_back(n);
    sb_sel.push_back(sel);
    sb_exp.push_back(v);
  endtask

  // Monitor: outputs are valid every cycle; compare at the quiet edge
  always @(negedge clock) begin
    while (sb_exp.size() > 0) begin
      string       n;
      int          sel;
      logic [31:0] e;
      logic [31:0] act;
      n   = sb_name.pop_front();
      sel = sb_sel.pop_front();
      e   = sb_exp.pop_front();
      act = (sel == 0) ? rd1 : (sel == 1) ? rd2 : wcnt;
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got=%08h want=%08h", n, act, e);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus   = '0;
    ra1   = '0;
    ra2   = '0;

    // Power-on reset state
    step(1, 0, 0, 4'h0, 32'h0, 5, 3);
    expect_v("por_rd1", 0, 32'h0);
    expect_v("por_cnt", 2, 32'h0);

    // 1: write r5, then async reset mid-cycle
    step(0, 1, 5, 4'hF, 32'h12345678, 0, 0);
    step(0, 0, 0, 4'h0, 32'h0, 5, 0);
    expect_v("t1_r5", 0, 32'h12345678);
    expect_v("t1_cnt", 2, 32'd1);
    step(1, 0, 0, 4'h0, 32'h0, 5, 5);
    expect_v("t1_rst_rd1", 0, 32'h0);
    expect_v("t1_rst_rd2", 1, 32'h0);
    expect_v("t1_rst_cnt", 2, 32'h0);

    // 2: full write r3, same-cycle read on port 2, next-cycle on port 1
    step(0, 1, 3, 4'hF, 32'hDEADBEEF, 0, 3);
`ifdef REGFILE_WRITE_BYPASS_EN
    expect_v("t2_byp", 1, 32'hDEADBEEF);
`else
    expect_v("t2_byp", 1, 32'h0);
`endif
    step(0, 0, 0, 4'h0, 32'h0, 3, 0);
    expect_v("t2_r3", 0, 32'hDEADBEEF);
    expect_v("t2_cnt", 2, 32'd1);

    // 3: byte-lane partial writes
    step(0, 1, 3, 4'h1, 32'h000000AA, 0, 0);
    step(0, 0, 0, 4'h0, 32'h0, 3, 0);
    expect_v("t3_lane0", 0, 32'hDEADBEAA);
    expect_v("t3_cnt_a", 2, 32'd2);
    step(0, 1, 3, 4'hC, 32'h55660000, 0, 0);
    step(0, 0, 0, 4'h0, 32'h0, 3, 0);
    expect_v("t3_lane32", 0, 32'h5566BEAA);
    expect_v("t3_cnt_b", 2, 32'd3);

    // 4: writes to $0 and with empty strobe are discarded
    step(0, 1, 0, 4'hF, 32'hFFFFFFFF, 0, 0);
    expect_v("t4_r0_same1", 0, 32'h0);
    expect_v("t4_r0_same2", 1, 32'h0);
    step(0, 1, 7, 4'h0, 32'hFFFFFFFF, 0, 7);
    expect_v("t4_r0_after", 0, 32'h0);
    expect_v("t4_cnt_r0", 2, 32'd3);
    expect_v("t4_r7_same", 1, 32'h0);
    step(0, 0, 0, 4'h0, 32'h0, 7, 0);
    expect_v("t4_r7", 0, 32'h0);
    expect_v("t4_cnt_s0", 2, 32'd3);

    // 5: read-during-write of a partial update
    step(0, 1, 9, 4'hF, 32'h11111111, 0, 0);
    step(0, 1, 9, 4'h3, 32'h22222222, 9, 9);
`ifdef REGFILE_WRITE_BYPASS_EN
    expect_v("t5_same", 1, 32'h11112222);
`else
    expect_v("t5_same", 1, 32'h11111111);
`endif
    expect_v("t5_cnt_pre", 2, 32'd4);
    step(0, 0, 0, 4'h0, 32'h0, 0, 9);
    expect_v("t5_next", 1, 32'h11112222);
    expect_v("t5_cnt", 2, 32'd5);

    // 6: write to r4 dropped under reset, both ports read it
    step(1, 1, 4, 4'hF, 32'h77777777, 4, 4);
    expect_v("t6_rst_rd1", 0, 32'h0);
    expect_v("t6_rst_rd2", 1, 32'h0);
    step(0, 0, 0, 4'h0, 32'h0, 4, 4);
    expect_v("t6_rd1", 0, 32'h0);
    expect_v("t6_rd2", 1, 32'h0);
    expect_v("t6_cnt", 2, 32'h0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb_exp.size() > 0; i++) @(posedge clock);
    if (sb_exp.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: left=%0d want=0", sb_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
